// File: rtl/clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl
//   Two independent programmable clock dividers: a write channel (w) and a
//   read channel (r). Each divided clock is a registered 50% duty square wave
//   with period 2*(div+1) clk cycles. New settings arrive through a shared
//   configuration port. A running channel picks up a new setting only at its
//   next period boundary, which is the falling edge of its divided clock.
//
// Ports
//   clk          system clock (rising edge)
//   reset        asynchronous, active-high reset
//   cfg_valid    configuration request
//   cfg_ready    request accepted when cfg_valid && cfg_ready
//   cfg_sel      0 = write channel, 1 = read channel
//   cfg_div      new half-period length minus 1
//   cfg_en       new channel enable
//   w_clk/r_clk  divided clocks
//   w_rise/r_rise one-cycle pulse in the first high cycle of each period
//   w_pend/r_pend staged configuration waiting for the period boundary
//   w_state_dbg/r_state_dbg channel FSM state (0 STOP, 1 RUN, 2 PEND)
//
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on cfg_sel and registered
// state, never on cfg_valid. A requester that sees cfg_ready low keeps its
// request and its payload stable until the transfer happens.
// ----------------------------------------------------------------------------

// One divider channel: counter, output toggle and the STOP/RUN/PEND FSM.
module clk_div_chan #(
    parameter int CNT_W   = 4,
    parameter int DIV_RST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_i,      // accepted request for this channel
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_en_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             pend_o,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] stg_div_q, stg_div_d;
    logic             stg_en_q, stg_en_d;

    logic running;
    logic tc;
    logic boundary;

    assign running  = (state_q != ST_STOP);
    assign tc       = (cnt_q == div_cur_q);
    // The falling toggle ends a period.
    assign boundary = running && tc && out_q;

    // State register (together with the datapath registers).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            div_cur_q <= CNT_W'(DIV_RST);
            cnt_q     <= '0;
            out_q     <= 1'b0;
            rise_q    <= 1'b0;
            stg_div_q <= '0;
            stg_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cur_q <= div_cur_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            stg_div_q <= stg_div_d;
            stg_en_q  <= stg_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (acc_i) state_d = ST_PEND;
            ST_PEND: if (boundary) state_d = stg_en_q ? ST_RUN : ST_STOP;
            ST_STOP: if (acc_i && cfg_en_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath next values.
    always_comb begin
        div_cur_d = div_cur_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        rise_d    = 1'b0;
        stg_div_d = stg_div_q;
        stg_en_d  = stg_en_q;

        if (running) begin
            if (tc) begin
                cnt_d  = '0;
                out_d  = ~out_q;
                rise_d = ~out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A request accepted on a boundary cycle leaves the channel in RUN
        // for that boundary, so the staged setting waits a full period more.
        if (state_q == ST_RUN && acc_i) begin
            stg_div_d = cfg_div_i;
            stg_en_d  = cfg_en_i;
        end

        if (state_q == ST_PEND && boundary) begin
            div_cur_d = stg_div_q;
            cnt_d     = '0;
            out_d     = 1'b0;
            stg_div_d = '0;
            stg_en_d  = 1'b0;
        end

        if (state_q == ST_STOP && acc_i && cfg_en_i) begin
            div_cur_d = cfg_div_i;
            cnt_d     = '0;
            out_d     = 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        clk_o   = out_q;
        rise_o  = rise_q;
        pend_o  = (state_q == ST_PEND);
        state_o = state_q;
    end
endmodule

module clk_div_ctrl #(
    parameter int CNT_W     = 4,
    parameter int W_DIV_RST = 2,
    parameter int R_DIV_RST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             w_clk,
    output logic             r_clk,
    output logic             w_rise,
    output logic             r_rise,
    output logic             w_pend,
    output logic             r_pend,
    output logic [1:0]       w_state_dbg,
    output logic [1:0]       r_state_dbg
);
    logic ready;
    logic w_acc;
    logic r_acc;

    assign ready     = cfg_sel ? ~r_pend : ~w_pend;
    assign cfg_ready = ready;
    assign w_acc     = cfg_valid && ready && !cfg_sel;
    assign r_acc     = cfg_valid && ready &&  cfg_sel;

    clk_div_chan #(.CNT_W(CNT_W), .DIV_RST(W_DIV_RST)) u_w (
        .clk      (clk),
        .reset    (reset),
        .acc_i    (w_acc),
        .cfg_div_i(cfg_div),
        .cfg_en_i (cfg_en),
        .clk_o    (w_clk),
        .rise_o   (w_rise),
        .pend_o   (w_pend),
        .state_o  (w_state_dbg)
    );

    clk_div_chan #(.CNT_W(CNT_W), .DIV_RST(R_DIV_RST)) u_r (
        .clk      (clk),
        .reset    (reset),
        .acc_i    (r_acc),
        .cfg_div_i(cfg_div),
        .cfg_en_i (cfg_en),
        .clk_o    (r_clk),
        .rise_o   (r_rise),
        .pend_o   (r_pend),
        .state_o  (r_state_dbg)
    );
endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;
  logic             w_clk, r_clk, w_rise, r_rise, w_pend, r_pend;
  logic [1:0]       w_state_dbg, r_state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Cycle index: number of rising edges since reset release.
  logic [31:0] cyc;

  // Expected rise cycles per channel.
  logic [31:0] w_exp_q[$];
  logic [31:0] r_exp_q[$];

  clk_div_ctrl #(.CNT_W(CNT_W), .W_DIV_RST(2), .R_DIV_RST(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sel    (cfg_sel),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .w_clk      (w_clk),
    .r_clk      (r_clk),
    .w_rise     (w_rise),
    .r_rise     (r_rise),
    .w_pend     (w_pend),
    .r_pend     (r_pend),
    .w_state_dbg(w_state_dbg),
    .r_state_dbg(r_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 32'd0;
    else       cyc <= cyc + 32'd1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every observed rise pops the next expected rise cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_rise) begin
        check_eq("w_rise_clk", {31'd0, w_clk}, 32'd1);
        if (w_exp_q.size() == 0) check_eq("w_rise_extra", cyc, 32'd0);
        else                     check_eq("w_rise_cyc", cyc, w_exp_q.pop_front());
      end
      if (r_rise) begin
        check_eq("r_rise_clk", {31'd0, r_clk}, 32'd1);
        if (r_exp_q.size() == 0) check_eq("r_rise_extra", cyc, 32'd0);
        else                     check_eq("r_rise_cyc", cyc, r_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_rises(input int ch, input int first, input int per, input int last);
    for (int t = first; t <= last; t += per) begin
      if (ch == 0) w_exp_q.push_back(32'(t));
      else         r_exp_q.push_back(32'(t));
    end
  endtask

  // Advance to 1 time unit after the falling edge following rising edge k.
  task automatic step_to(input int k);
    while (cyc < 32'(k)) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wclk"}, {31'd0, w_clk}, 32'd0);
    check_eq({tag, "_rclk"}, {31'd0, r_clk}, 32'd0);
    check_eq({tag, "_rise"}, {30'd0, w_rise, r_rise}, 32'd0);
    check_eq({tag, "_pend"}, {30'd0, w_pend, r_pend}, 32'd0);
    cfg_sel = 1'b0;
    #1;
    check_eq({tag, "_rdy_w"}, {31'd0, cfg_ready}, 32'd1);
    cfg_sel = 1'b1;
    #1;
    check_eq({tag, "_rdy_r"}, {31'd0, cfg_ready}, 32'd1);
    cfg_sel = 1'b0;
  endtask

  task automatic apply_reset();
    cfg_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_a");
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_reset_outputs("rst_b");
    check_eq("rst_wstate", {30'd0, w_state_dbg}, 32'd1);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive_cfg(input logic sel, input logic [CNT_W-1:0] div, input logic en,
                           input logic exp_ready, input string tag);
    cfg_sel   = sel;
    cfg_div   = div;
    cfg_en    = en;
    cfg_valid = 1'b1;
    #1;
    check_eq(tag, {31'd0, cfg_ready}, {31'd0, exp_ready});
  endtask

  task automatic phase_end(input string tag);
    check_eq({tag, "_wq_left"}, 32'(w_exp_q.size()), 32'd0);
    check_eq({tag, "_rq_left"}, 32'(r_exp_q.size()), 32'd0);
    w_exp_q.delete();
    r_exp_q.delete();
  endtask

  task automatic reset_timing(input int last, input string tag);
    push_rises(0, 3, 6, last);
    push_rises(1, 2, 4, last);
    step_to(3);
    check_eq({tag, "_w_hi3"}, {31'd0, w_clk}, 32'd1);
    step_to(5);
    check_eq({tag, "_w_hi5"}, {31'd0, w_clk}, 32'd1);
    step_to(6);
    check_eq({tag, "_w_lo6"}, {31'd0, w_clk}, 32'd0);
    check_eq({tag, "_r_hi6"}, {31'd0, r_clk}, 32'd1);
    step_to(8);
    check_eq({tag, "_r_lo8"}, {31'd0, r_clk}, 32'd0);
    step_to(last);
    phase_end(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_div   = '0;
    cfg_en    = 1'b0;

    // Reset timing with no configuration.
    apply_reset();
    reset_timing(30, "p1");

    // Mid-high reconfiguration of w, stop then restart of r.
    apply_reset();
    push_rises(0, 3, 6, 3);
    push_rises(1, 2, 4, 2);
    step_to(4);
    check_eq("p2_w_hi4", {31'd0, w_clk}, 32'd1);
    drive_cfg(1'b0, 4'd4, 1'b1, 1'b1, "p2_w_ready");
    push_rises(0, 11, 10, 32);
    step_to(5);
    cfg_valid = 1'b0;
    check_eq("p2_w_pend5", {31'd0, w_pend}, 32'd1);
    drive_cfg(1'b0, 4'd9, 1'b1, 1'b0, "p2_w_busy");
    drive_cfg(1'b1, 4'd2, 1'b0, 1'b1, "p2_r_ready");
    push_rises(1, 6, 4, 6);
    step_to(6);
    cfg_valid = 1'b0;
    check_eq("p2_w_pend6", {31'd0, w_pend}, 32'd0);
    check_eq("p2_w_lo6", {31'd0, w_clk}, 32'd0);
    check_eq("p2_r_pend6", {31'd0, r_pend}, 32'd1);
    step_to(8);
    check_eq("p2_r_pend8", {31'd0, r_pend}, 32'd0);
    check_eq("p2_r_stop8", {30'd0, r_state_dbg}, 32'd0);
    check_eq("p2_r_lo8", {31'd0, r_clk}, 32'd0);
    drive_cfg(1'b1, 4'd3, 1'b0, 1'b1, "p2_r_ready_stop");
    step_to(9);
    cfg_valid = 1'b0;
    check_eq("p2_r_pend9", {31'd0, r_pend}, 32'd0);
    check_eq("p2_r_stop9", {30'd0, r_state_dbg}, 32'd0);
    step_to(10);
    drive_cfg(1'b1, 4'd0, 1'b1, 1'b1, "p2_r_ready_go");
    push_rises(1, 12, 2, 32);
    step_to(11);
    cfg_valid = 1'b0;
    step_to(16);
    check_eq("p2_w_lo16", {31'd0, w_clk}, 32'd0);
    step_to(32);
    phase_end("p2");

    // Accept on a boundary cycle, then reset while pending.
    apply_reset();
    push_rises(0, 3, 6, 9);
    push_rises(1, 2, 4, 15);
    step_to(5);
    check_eq("p3_w_hi5", {31'd0, w_clk}, 32'd1);
    drive_cfg(1'b0, 4'd0, 1'b1, 1'b1, "p3_w_ready");
    push_rises(0, 13, 2, 15);
    step_to(6);
    cfg_valid = 1'b0;
    check_eq("p3_w_pend6", {31'd0, w_pend}, 32'd1);
    step_to(11);
    check_eq("p3_w_pend11", {31'd0, w_pend}, 32'd1);
    step_to(12);
    check_eq("p3_w_pend12", {31'd0, w_pend}, 32'd0);
    check_eq("p3_w_run12", {30'd0, w_state_dbg}, 32'd1);
    step_to(14);
    drive_cfg(1'b0, 4'd7, 1'b1, 1'b1, "p3_w_ready2");
    step_to(15);
    cfg_valid = 1'b0;
    check_eq("p3_w_pend15", {31'd0, w_pend}, 32'd1);
    phase_end("p3");
    apply_reset();
    reset_timing(20, "p4");

    // Maximum divider: period 32.
    apply_reset();
    push_rises(0, 3, 6, 3);
    push_rises(1, 2, 4, 90);
    step_to(4);
    drive_cfg(1'b0, 4'd15, 1'b1, 1'b1, "p5_w_ready");
    push_rises(0, 22, 32, 90);
    step_to(5);
    cfg_valid = 1'b0;
    step_to(21);
    check_eq("p5_w_lo21", {31'd0, w_clk}, 32'd0);
    step_to(22);
    check_eq("p5_w_hi22", {31'd0, w_clk}, 32'd1);
    step_to(37);
    check_eq("p5_w_hi37", {31'd0, w_clk}, 32'd1);
    step_to(38);
    check_eq("p5_w_lo38", {31'd0, w_clk}, 32'd0);
    step_to(90);
    phase_end("p5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
